mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath (PC/NPC, IR, GPR, ALU, unified memory) over several clocks per instruction.
- Replaces single-cycle combinational decode.
- Supports addu, subu, ori, lui, lw, sw, beq, j.
- Handles a req/ready memory handshake with arbitrary wait states, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- ALU_W, 4, width of alu_ctl

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- opcode  in  6  IR[31:26], stable from DECODE until next fetch completes
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (sw), 0 = read
- ir_wr  out  1  load IR from memory read data
- pc_wr  out  1  load PC from NPC mux
- npc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- reg_wr  out  1  GPR write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data, 0 = ALU result
- alu_src  out  1  1 = extended imm16, 0 = GPR rd2
- ext_op  out  1  1 = sign extend, 0 = zero extend
- alu_ctl  out  ALU_W  0000 ADDU, 0001 SUBU, 0010 OR, 0011 LUI (B<<16)
- illegal  out  1  sticky illegal-instruction flag
- retired  out  CNT_W  retired-instruction count
- state  out  4  current state (debug)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, illegal=0, retired=0.
  - All outputs forced 0 while rst=0, including mem_req.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB_R 4, WB_I 5, MEM_ADDR 6, MEM_RD 7, MEM_WR 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 12.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ready=1: ir_wr=1, pc_wr=1, npc_sel=0, then go to DECODE. Otherwise stay, with ir_wr=pc_wr=0.
- DECODE:
  - R-type (opcode 000000) with funct 100001 or 100011 -> EXEC_R.
  - 001101 / 001111 -> EXEC_I.
  - 100011 / 101011 -> MEM_ADDR.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - Anything else -> TRAP.
- EXEC_R: alu_src=0; alu_ctl = ADDU or SUBU per funct. Next state WB_R.
- WB_R: reg_wr=1, reg_dst=1, mem_to_reg=0; ALU controls held. Next state FETCH.
- EXEC_I: alu_src=1, ext_op=0; alu_ctl = OR (ori) or LUI (lui). Next state WB_I.
- WB_I: reg_wr=1, reg_dst=0, mem_to_reg=0; ALU controls held. Next state FETCH.
- MEM_ADDR: alu_src=1, ext_op=1, alu_ctl=ADDU. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, mem_we=0; ALU controls held. Waits for mem_ready=1, then WB_MEM.
- MEM_WR: mem_req=1, mem_we=1; ALU controls held. Waits for mem_ready=1, then FETCH.
- WB_MEM: reg_wr=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- BRANCH: alu_src=0, alu_ctl=SUBU, npc_sel=1, pc_wr=alu_zero (Mealy). Next state FETCH.
- JUMP: pc_wr=1, npc_sel=2. Next state FETCH.
- TRAP:
  - illegal=1 (registered, set on entry), all enables 0.
  - Stays in TRAP until reset; pc_wr and reg_wr are never asserted.
- Output timing:
  - All outputs are decoded from state plus opcode/funct (Moore).
  - Exceptions are FETCH ir_wr/pc_wr (gated by mem_ready) and BRANCH pc_wr (gated by alu_zero).
  - Unlisted outputs are 0 in every state.
- Handshake:
  - mem_req stays high until mem_ready is sampled high.
  - mem_ready in the first request cycle is legal (zero wait).
  - mem_ready while mem_req=0 is ignored.
  - mem_we stays constant for the whole request.
- retired:
  - Increments by 1 on each transition into FETCH from WB_R, WB_I, WB_MEM, MEM_WR, BRANCH or JUMP.
  - Wraps modulo 2^CNT_W.
- Latency with zero-wait memory, in clocks:
  - addu/subu/ori/lui: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - Each memory wait cycle adds 1 clock.
- Reset mid-operation (any state, including mid-handshake): immediate return to FETCH, mem_req drops asynchronously, counter cleared.

Test Plan:
- Zero-wait addu (op 000000, funct 100001) -> states 0,1,2,4; reg_wr=1 and reg_dst=1 only in the 4th cycle; retired 0->1.
- lw with mem_ready held low 3 cycles in MEM_RD -> mem_req=1, mem_we=0 for 4 cycles; WB_MEM has reg_wr=1, mem_to_reg=1; total 8 clocks.
- beq with alu_zero=1 -> pc_wr=1, npc_sel=1 in BRANCH. Repeat with alu_zero=0 -> pc_wr=0; both retire (+1).
- opcode 111111 -> TRAP, illegal=1 held for 20 cycles, no pc_wr/reg_wr; rst pulse -> illegal=0, state=0.
- rst asserted in MEM_WR with mem_ready=0 -> mem_req=0 immediately; after release state=FETCH, retired=0.
- Preload retired near max (CNT_W=4 build, 16 retired instructions) -> wraps to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over
// the shared datapath, with a req/ready memory handshake, illegal-opcode trap and retire counter.
module mc_ctrl #(
    parameter int CNT_W = 32,
    parameter int ALU_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       npc_sel,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic             ext_op,
    output logic [ALU_W-1:0] alu_ctl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [ALU_W-1:0] ALU_ADDU = ALU_W'(4'd0);
    localparam logic [ALU_W-1:0] ALU_SUBU = ALU_W'(4'd1);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(4'd2);
    localparam logic [ALU_W-1:0] ALU_LUI  = ALU_W'(4'd3);

    localparam logic [1:0] NPC_SEQ  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        case (op)
            OP_RTYPE: begin
                if ((fn == FN_ADDU) || (fn == FN_SUBU)) begin
                    nxt = ST_EXEC_R;
                end else begin
                    nxt = ST_TRAP;
                end
            end
            OP_ORI, OP_LUI: nxt = ST_EXEC_I;
            OP_LW, OP_SW:   nxt = ST_MEM_ADDR;
            OP_BEQ:         nxt = ST_BRANCH;
            OP_J:           nxt = ST_JUMP;
            default:        nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

    function automatic logic [ALU_W-1:0] r_alu(input logic [5:0] fn);
        logic [ALU_W-1:0] ctl;
        if (fn == FN_SUBU) begin
            ctl = ALU_SUBU;
        end else begin
            ctl = ALU_ADDU;
        end
        return ctl;
    endfunction

    function automatic logic [ALU_W-1:0] i_alu(input logic [5:0] op);
        logic [ALU_W-1:0] ctl;
        if (op == OP_LUI) begin
            ctl = ALU_LUI;
        end else begin
            ctl = ALU_OR;
        end
        return ctl;
    endfunction

    state_t           state_r;
    state_t           decode_next_s;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] retired_inc_s;

    assign decode_next_s = decode_next(opcode, funct);
    assign retired_inc_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // State sequencing, sticky illegal flag and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
            retired_r <= '0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    state_r <= decode_next_s;
                    if (decode_next_s == ST_TRAP) begin
                        illegal_r <= 1'b1;
                    end
                end
                ST_EXEC_R:   state_r <= ST_WB_R;
                ST_EXEC_I:   state_r <= ST_WB_I;
                ST_MEM_ADDR: begin
                    if (opcode == OP_LW) begin
                        state_r <= ST_MEM_RD;
                    end else begin
                        state_r <= ST_MEM_WR;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        state_r <= ST_WB_MEM;
                    end else begin
                        state_r <= ST_MEM_RD;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        state_r   <= ST_FETCH;
                        retired_r <= retired_inc_s;
                    end else begin
                        state_r <= ST_MEM_WR;
                    end
                end
                ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
                    state_r   <= ST_FETCH;
                    retired_r <= retired_inc_s;
                end
                ST_TRAP: state_r <= ST_TRAP;
                // Unused encodings are treated as a fault and parked in TRAP.
                default: begin
                    state_r   <= ST_TRAP;
                    illegal_r <= 1'b1;
                end
            endcase
        end
    end

    // Moore control decode; reset gates everything low so mem_req drops immediately.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        npc_sel    = NPC_SEQ;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        alu_ctl    = ALU_ADDU;
        if (rst) begin
            case (state_r)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_wr   = mem_ready;
                    pc_wr   = mem_ready;
                end
                ST_EXEC_R: begin
                    alu_ctl = r_alu(funct);
                end
                ST_WB_R: begin
                    reg_wr  = 1'b1;
                    reg_dst = 1'b1;
                    alu_ctl = r_alu(funct);
                end
                ST_EXEC_I: begin
                    alu_src = 1'b1;
                    alu_ctl = i_alu(opcode);
                end
                ST_WB_I: begin
                    reg_wr  = 1'b1;
                    alu_src = 1'b1;
                    alu_ctl = i_alu(opcode);
                end
                ST_MEM_ADDR: begin
                    alu_src = 1'b1;
                    ext_op  = 1'b1;
                end
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    alu_src = 1'b1;
                    ext_op  = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    alu_src = 1'b1;
                    ext_op  = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_wr     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_BRANCH: begin
                    alu_ctl = ALU_SUBU;
                    npc_sel = NPC_BR;
                    pc_wr   = alu_zero;
                end
                ST_JUMP: begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_JUMP;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    assign illegal = illegal_r;
    assign retired = retired_r;
    assign state   = state_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table for each instruction class,
// plus hand-written trap, async-reset and counter-wrap sequences.
module tb_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;

    logic        mem_req, mem_we, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg, alu_src, ext_op, illegal;
    logic [1:0]  npc_sel;
    logic [3:0]  alu_ctl;
    logic [31:0] retired;
    logic [3:0]  state;

    logic        mem_req4, mem_we4, ir_wr4, pc_wr4, reg_wr4, reg_dst4, mem_to_reg4, alu_src4, ext_op4, illegal4;
    logic [1:0]  npc_sel4;
    logic [3:0]  alu_ctl4;
    logic [3:0]  retired4;
    logic [3:0]  state4;

    mc_ctrl u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_wr(ir_wr),
        .pc_wr(pc_wr), .npc_sel(npc_sel), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_op(ext_op), .alu_ctl(alu_ctl),
        .illegal(illegal), .retired(retired), .state(state)
    );

    mc_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req4), .mem_we(mem_we4), .ir_wr(ir_wr4),
        .pc_wr(pc_wr4), .npc_sel(npc_sel4), .reg_wr(reg_wr4), .reg_dst(reg_dst4),
        .mem_to_reg(mem_to_reg4), .alu_src(alu_src4), .ext_op(ext_op4), .alu_ctl(alu_ctl4),
        .illegal(illegal4), .retired(retired4), .state(state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] act_outs;
    assign act_outs = {mem_req, mem_we, ir_wr, pc_wr, npc_sel, reg_wr, reg_dst,
                       mem_to_reg, alu_src, ext_op, alu_ctl};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] outs;
        logic [31:0] ret;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [14:0] o(input logic req, input logic we, input logic ir,
                                      input logic pc, input logic [1:0] npc, input logic rw,
                                      input logic rd, input logic m2r, input logic src,
                                      input logic ext, input logic [3:0] alu);
        return {req, we, ir, pc, npc, rw, rd, m2r, src, ext, alu};
    endfunction

    function automatic vec_t r(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                               input logic rdy, input logic [3:0] st, input logic [14:0] outs,
                               input logic [31:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.zero = zero; v.rdy = rdy; v.st = st; v.outs = outs; v.ret = ret;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        opcode = op; funct = fn; alu_zero = z; mem_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] fgo, fwait, zero_o;

    initial begin
        fgo    = o(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        fwait  = o(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        zero_o = 15'd0;

        // addu
        vq.push_back(r(OP_R, F_ADDU, 1'b0, 1'b1, 4'd0, fgo, 32'd0));
        vq.push_back(r(OP_R, F_ADDU, 1'b0, 1'b0, 4'd1, zero_o, 32'd0));
        vq.push_back(r(OP_R, F_ADDU, 1'b0, 1'b0, 4'd2, zero_o, 32'd0));
        vq.push_back(r(OP_R, F_ADDU, 1'b0, 1'b0, 4'd4, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0), 32'd0));
        // subu with one fetch wait
        vq.push_back(r(OP_R, F_SUBU, 1'b0, 1'b0, 4'd0, fwait, 32'd1));
        vq.push_back(r(OP_R, F_SUBU, 1'b0, 1'b1, 4'd0, fgo, 32'd1));
        vq.push_back(r(OP_R, F_SUBU, 1'b0, 1'b0, 4'd1, zero_o, 32'd1));
        vq.push_back(r(OP_R, F_SUBU, 1'b0, 1'b0, 4'd2, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1), 32'd1));
        vq.push_back(r(OP_R, F_SUBU, 1'b0, 1'b0, 4'd4, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd1), 32'd1));
        // ori
        vq.push_back(r(OP_ORI, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd2));
        vq.push_back(r(OP_ORI, 6'd0, 1'b0, 1'b0, 4'd1, zero_o, 32'd2));
        vq.push_back(r(OP_ORI, 6'd0, 1'b0, 1'b0, 4'd3, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,4'd2), 32'd2));
        vq.push_back(r(OP_ORI, 6'd0, 1'b0, 1'b0, 4'd5, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b1,1'b0,4'd2), 32'd2));
        // lui
        vq.push_back(r(OP_LUI, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd3));
        vq.push_back(r(OP_LUI, 6'd0, 1'b0, 1'b0, 4'd1, zero_o, 32'd3));
        vq.push_back(r(OP_LUI, 6'd0, 1'b0, 1'b0, 4'd3, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,4'd3), 32'd3));
        vq.push_back(r(OP_LUI, 6'd0, 1'b0, 1'b0, 4'd5, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b1,1'b0,4'd3), 32'd3));
        // lw, ready ignored in DECODE, 3 wait cycles in MEM_RD
        vq.push_back(r(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd4));
        vq.push_back(r(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, zero_o, 32'd4));
        vq.push_back(r(OP_LW, 6'd0, 1'b0, 1'b0, 4'd6, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,4'd0), 32'd4));
        for (int i = 0; i < 4; i++) begin
            vq.push_back(r(OP_LW, 6'd0, 1'b0, (i == 3) ? 1'b1 : 1'b0, 4'd7,
                           o(1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,4'd0), 32'd4));
        end
        vq.push_back(r(OP_LW, 6'd0, 1'b0, 1'b0, 4'd9, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,4'd0), 32'd4));
        // sw with one wait cycle
        vq.push_back(r(OP_SW, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd5));
        vq.push_back(r(OP_SW, 6'd0, 1'b0, 1'b0, 4'd1, zero_o, 32'd5));
        vq.push_back(r(OP_SW, 6'd0, 1'b0, 1'b0, 4'd6, o(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,4'd0), 32'd5));
        vq.push_back(r(OP_SW, 6'd0, 1'b0, 1'b0, 4'd8, o(1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,4'd0), 32'd5));
        vq.push_back(r(OP_SW, 6'd0, 1'b0, 1'b1, 4'd8, o(1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,4'd0), 32'd5));
        // beq taken then not taken
        vq.push_back(r(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd6));
        vq.push_back(r(OP_BEQ, 6'd0, 1'b0, 1'b0, 4'd1, zero_o, 32'd6));
        vq.push_back(r(OP_BEQ, 6'd0, 1'b1, 1'b0, 4'd10, o(1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1), 32'd6));
        vq.push_back(r(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd7));
        vq.push_back(r(OP_BEQ, 6'd0, 1'b1, 1'b0, 4'd1, zero_o, 32'd7));
        vq.push_back(r(OP_BEQ, 6'd0, 1'b0, 1'b0, 4'd10, o(1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1), 32'd7));
        // j
        vq.push_back(r(OP_J, 6'd0, 1'b0, 1'b1, 4'd0, fgo, 32'd8));
        vq.push_back(r(OP_J, 6'd0, 1'b0, 1'b0, 4'd1, zero_o, 32'd8));
        vq.push_back(r(OP_J, 6'd0, 1'b0, 1'b0, 4'd11, o(1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0), 32'd8));
        vq.push_back(r(OP_J, 6'd0, 1'b0, 1'b0, 4'd0, fwait, 32'd9));

        // reset state, with mem_ready high to expose any ungated output
        rst = 1'b0;
        drive(OP_R, F_ADDU, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {17'd0, act_outs}, 32'd0);
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        check("reset_retired", retired, 32'd0);
        check("reset_retired4", {28'd0, retired4}, 32'd0);
        next_cycle();
        rst = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].op, vq[i].fn, vq[i].zero, vq[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vq[i].st});
            check($sformatf("vec%0d_outs", i), {17'd0, act_outs}, {17'd0, vq[i].outs});
            check($sformatf("vec%0d_retired", i), retired, vq[i].ret);
            check($sformatf("vec%0d_illegal", i), {31'd0, illegal}, 32'd0);
            next_cycle();
        end

        // illegal opcode: trap and hold for 20 cycles
        drive(OP_BAD, 6'd0, 1'b0, 1'b1);
        next_cycle();
        check("trap_decode_state", {28'd0, state}, 32'd1);
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            drive(OP_BAD, 6'd0, ~i[0], i[0]);
            @(negedge clk);
            check($sformatf("trap%0d", i), {11'd0, retired[3:0], illegal, act_outs, state} ,
                  {11'd0, 4'd9, 1'b1, 15'd0, 4'd12});
            next_cycle();
        end
        rst = 1'b0;
        #1;
        check("trap_rst_async", {11'd0, retired[3:0], illegal, act_outs, state}, 32'd0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        check("trap_rst_outs", {13'd0, act_outs, state}, {13'd0, fgo, 4'd0});

        // reset in the middle of an sw handshake
        drive(OP_J, 6'd0, 1'b0, 1'b1);
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        check("pre_sw_retired", retired, 32'd1);
        drive(OP_SW, 6'd0, 1'b0, 1'b1);
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("sw_wait_req", {26'd0, mem_req, mem_we, state}, {26'd0, 1'b1, 1'b1, 4'd8});
        #2;
        rst = 1'b0;
        #1;
        check("sw_rst_req", {30'd0, mem_req, mem_we}, 32'd0);
        check("sw_rst_retired", retired, 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("sw_rel_state", {13'd0, act_outs, state}, {13'd0, fwait, 4'd0});
        check("sw_rel_retired", retired, 32'd0);
        next_cycle();

        // 17 jumps: the 4-bit counter wraps after 16
        for (int k = 1; k <= 17; k++) begin
            drive(OP_J, 6'd0, 1'b0, 1'b1);
            next_cycle();
            mem_ready = 1'b0;
            next_cycle();
            next_cycle();
            check($sformatf("wrap%0d_retired", k), retired, k);
            check($sformatf("wrap%0d_retired4", k), {28'd0, retired4}, k % 16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
